// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial BCD adder: one shared 1-digit adder walks the operands LSD first
// The single digit adder is reused once per cycle; operands are latched at accept so inputs may change freely.

module bcd_fadd_1digit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] bin;

    // Decimal correction: any binary sum above 9 gets +6 and produces a carry.
    always_comb begin
        bin  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout = (bin > 5'd9);
        s    = cout ? (bin[3:0] + 4'd6) : bin[3:0];
    end
endmodule

module bcd_serial_add_ctrl #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   sum,
    output logic                   cout,
    output logic                   err
);
    localparam int W  = 4 * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            cout_q;
    logic            err_q;
    logic            accept;
    logic            last_digit;
    logic            bad_in;
    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [3:0]      fa_s;
    logic            fa_c;

    assign a_dig = a_q[{idx, 2'b00} +: 4];
    assign b_dig = b_q[{idx, 2'b00} +: 4];

    bcd_fadd_1digit u_fadd (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                bad_in = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        last_digit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    last_digit = 1'b1;
                    state_nxt  = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                carry  <= cin;
                idx    <= '0;
                sum_q  <= '0;
                err_q  <= bad_in;
                cout_q <= 1'b0;
            end else if (state == RUN) begin
                sum_q[{idx, 2'b00} +: 4] <= fa_s;
                carry                    <= fa_c;
                // Wrap rather than increment so the index stays in range for non-power-of-two widths.
                if (last_digit) begin
                    idx    <= '0;
                    cout_q <= fa_c;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - directed self-checking bench for bcd_serial_add_ctrl with NDIGITS=4

module tb_bcd_serial_add_ctrl;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          cin = 1'b0;
    logic [15:0]   a = '0;
    logic [15:0]   b = '0;
    logic          busy;
    logic          done;
    logic [15:0]   sum;
    logic          cout;
    logic          err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.NDIGITS(ND)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic c, input logic [15:0] exp_sum, input logic exp_cout,
                          input logic exp_err);
        int nbusy;
        int ndone;
        int dpos;
        logic [15:0] s_at_done;
        logic c_at_done;
        logic e_at_done;
        nbusy = 0; ndone = 0; dpos = 0;
        s_at_done = 'x; c_at_done = 1'bx; e_at_done = 1'bx;
        @(negedge clk);
        a = av; b = bv; cin = c; start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; a = ~av; b = ~bv; cin = ~c;
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (dpos == 0) begin
                    dpos = i; s_at_done = sum; c_at_done = cout; e_at_done = err;
                end
            end
        end
        check({tag, "_latency"}, dpos, ND + 1);
        check({tag, "_busy_cycles"}, nbusy, ND + 1);
        check({tag, "_done_count"}, ndone, 1);
        check({tag, "_sum_at_done"}, {16'h0, s_at_done}, {16'h0, exp_sum});
        check({tag, "_cout_at_done"}, {31'h0, c_at_done}, {31'h0, exp_cout});
        check({tag, "_err_at_done"}, {31'h0, e_at_done}, {31'h0, exp_err});
        check({tag, "_sum_held"}, {16'h0, sum}, {16'h0, exp_sum});
        check({tag, "_cout_held"}, {31'h0, cout}, {31'h0, exp_cout});
    endtask

    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [15:0] vs [3];
    logic        vc [3];

    initial begin
        int ndone;
        int k;
        int last;
        bit pend;

        #1 rst = 1'b1;
        #1;
        check("rst_sum", {16'h0, sum}, 32'h0);
        check("rst_cout", {31'h0, cout}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("basic",   16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        run_op("ripple",  16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin_only",16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op("max",     16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);

        // Abort mid-RUN: outputs must drop without waiting for a clock edge.
        @(negedge clk);
        a = 16'h0011; b = 16'h0022; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_sum", {16'h0, sum}, 32'h0);
        check("abort_cout", {31'h0, cout}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_op("after_abort", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

        run_op("bad_digit", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
        check("bad_digit_err_held", {31'h0, err}, 32'h1);
        run_op("err_clear", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

        // start held high: each operation must use operands present at its own accept edge.
        va[0] = 16'h1111; vb[0] = 16'h2222; vs[0] = 16'h3333; vc[0] = 1'b0;
        va[1] = 16'h4567; vb[1] = 16'h5433; vs[1] = 16'h0000; vc[1] = 1'b1;
        va[2] = 16'h0909; vb[2] = 16'h0191; vs[2] = 16'h1100; vc[2] = 1'b0;
        k = 0; last = -1; pend = 1'b0;
        @(negedge clk);
        a = va[0]; b = vb[0]; cin = 1'b0; start = 1'b1;
        for (int cyc = 1; cyc <= 60 && k < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                check($sformatf("cont%0d_sum", k), {16'h0, sum}, {16'h0, vs[k]});
                check($sformatf("cont%0d_cout", k), {31'h0, cout}, {31'h0, vc[k]});
                if (last >= 0) check($sformatf("cont%0d_interval", k), cyc - last, ND + 2);
                last = cyc;
                k++;
                pend = 1'b1;
                a = 16'h7777; b = 16'h7777;
            end else if (pend) begin
                check($sformatf("cont%0d_idle_gap", k), {31'h0, busy}, 32'h0);
                pend = 1'b0;
                if (k < 3) begin
                    a = va[k]; b = vb[k];
                end
            end else begin
                a = 16'h7777; b = 16'h7777;
            end
        end
        start = 1'b0;
        check("cont_ops_completed", k, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
